fetch_decode_unit: RTL and testbench

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

---
 rtl/fetch_decode_unit_if.sv | 22 ++
 rtl/fetch_decode_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_decode_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_unit_if.sv
// Bus bundle between the fetch/decode sequencer, the halfword instruction
// memory and the bus interface unit (BIU).
interface fetch_decode_unit_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_data;
   logic        mem_ready;
   logic [31:0] ir;
   logic        biu_cs;
   logic [1:0]  biu_sel;
   logic        biu_ready;

   modport master (
      output mem_addr, mem_rd, ir, biu_cs, biu_sel,
      input  mem_data, mem_ready, biu_ready
   );

   modport slave (
      input  mem_addr, mem_rd, ir, biu_cs, biu_sel,
      output mem_data, mem_ready, biu_ready
   );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode sequencer: fetches each 32-bit instruction as two halfwords,
// decodes the BIU operation and runs the BIU request/complete handshake.
module fetch_decode_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned BIU_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   fetch_decode_unit_if.master bus,
   output logic [15:0]         pc,
   output logic                halted,
   output logic                err
);

   localparam int unsigned      TMO_W     = (BIU_TIMEOUT < 2) ? 1 : $clog2(BIU_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BIU_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      FETCH_HI,
      FETCH_LO,
      DECODE,
      DISPATCH,
      WAIT_BIU,
      HALT,
      ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [1:0]       sel_q, sel_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [TMO_W-1:0] tmo_inc;
   logic             tmo_hit;

   // The counter shares one increment for both handshake phases; it is
   // cleared on the transition into each phase.
   assign tmo_inc = tmo_q + TMO_W'(1);
   assign tmo_hit = (tmo_inc == TMO_LIMIT);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      sel_d   = sel_q;
      tmo_d   = tmo_q;

      unique case (state_q)
         IDLE: begin
            if (run && bus.biu_ready) state_d = FETCH_HI;
         end
         FETCH_HI: begin
            if (bus.mem_ready) begin
               ir_d[31:16] = bus.mem_data;
               state_d     = FETCH_LO;
            end
         end
         FETCH_LO: begin
            if (bus.mem_ready) begin
               ir_d[15:0] = bus.mem_data;
               pc_d       = pc_q + 16'd2;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            if (ir_q[31:30] == 2'b11) begin
               state_d = HALT;
            end else begin
               sel_d   = ir_q[31:30];
               tmo_d   = '0;
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            if (!bus.biu_ready) begin
               tmo_d   = '0;
               state_d = WAIT_BIU;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_hit) state_d = ERROR;
            end
         end
         WAIT_BIU: begin
            if (bus.biu_ready) begin
               state_d = run ? FETCH_HI : IDLE;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_hit) state_d = ERROR;
            end
         end
         HALT, ERROR: begin
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         sel_q   <= 2'b00;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         sel_q   <= sel_d;
         tmo_q   <= tmo_d;
      end
   end

   // Bus strobes decode straight from the registered state, so a timeout
   // drops biu_cs on the same edge that enters ERROR.
   always_comb begin
      bus.mem_rd   = 1'b0;
      bus.mem_addr = '0;
      bus.biu_cs   = 1'b0;
      unique case (state_q)
         FETCH_HI: begin
            bus.mem_rd   = 1'b1;
            bus.mem_addr = pc_q;
         end
         FETCH_LO: begin
            bus.mem_rd   = 1'b1;
            bus.mem_addr = pc_q + 16'd1;
         end
         DISPATCH: bus.biu_cs = 1'b1;
         default: begin
         end
      endcase
   end

   assign bus.ir      = ir_q;
   assign bus.biu_sel = sel_q;
   assign pc          = pc_q;
   assign halted      = (state_q == HALT);
   assign err         = (state_q == ERROR);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: memory and BIU models run once
// per negedge; expected fetch addresses and BIU selects are queued up front.
module tb_fetch_decode_unit;
   localparam int BIU_TO      = 20;
   localparam int BIU_LAT     = 5;
   localparam int WAIT_BUDGET = 300;
   localparam int W_CS        = 0;
   localparam int W_HALT      = 1;
   localparam int W_ERR       = 2;

   logic        clk = 1'b0;
   logic        rst, run, rst_w, run_w;
   logic [15:0] pc, pc_w;
   logic        halted, err, halted_w, err_w;

   fetch_decode_unit_if bus_m();
   fetch_decode_unit_if bus_w();

   fetch_decode_unit #(.RESET_PC(16'h0000), .BIU_TIMEOUT(BIU_TO)) dut (
      .clk(clk), .rst(rst), .run(run), .bus(bus_m),
      .pc(pc), .halted(halted), .err(err)
   );

   fetch_decode_unit #(.RESET_PC(16'hFFFE), .BIU_TIMEOUT(BIU_TO)) dut_w (
      .clk(clk), .rst(rst_w), .run(run_w), .bus(bus_w),
      .pc(pc_w), .halted(halted_w), .err(err_w)
   );

   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [15:0] mem [0:15];
   logic [15:0] addr_q[$];
   logic [15:0] addr_w_q[$];
   logic [1:0]  sel_q[$];
   int          mem_wait, mem_cnt;
   bit          mem_pending;
   logic [15:0] held_addr;
   bit          biu_force_low, biu_stuck, biu_busy;
   int          biu_cnt;
   logic        cs_prev;
   int          cs_pulses, cs_high, rd_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: advance to the negedge, then run the models and scoreboards.
   task automatic tick();
      @(negedge clk);
      // Main memory with mem_wait wait states per read.
      if (bus_m.mem_rd) begin
         rd_cnt++;
         if (mem_pending) begin
            check("mem_addr_hold", 32'(bus_m.mem_addr), 32'(held_addr));
         end
         if (mem_cnt == mem_wait) begin
            bus_m.mem_ready = 1'b1;
            bus_m.mem_data  = mem[bus_m.mem_addr[3:0]];
            mem_cnt         = 0;
            mem_pending     = 1'b0;
            check("fetch_q_nonempty", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) check("fetch_addr", 32'(bus_m.mem_addr), 32'(addr_q.pop_front()));
         end else begin
            bus_m.mem_ready = 1'b0;
            if (!mem_pending) held_addr = bus_m.mem_addr;
            mem_pending = 1'b1;
            mem_cnt++;
         end
      end else begin
         if (mem_pending) check("mem_rd_hold", 32'(bus_m.mem_rd), 32'd1);
         bus_m.mem_ready = 1'b0;
         mem_cnt         = 0;
         mem_pending     = 1'b0;
      end
      // BIU: drops ready one cycle after cs, raises it BIU_LAT cycles later.
      if (bus_m.biu_cs && !cs_prev) begin
         cs_pulses++;
         check("sel_q_nonempty", 32'(sel_q.size() != 0), 32'd1);
         if (sel_q.size() != 0) check("biu_sel_at_cs", 32'(bus_m.biu_sel), 32'(sel_q.pop_front()));
      end
      if (bus_m.biu_cs) cs_high++;
      cs_prev = bus_m.biu_cs;
      if (biu_force_low) begin
         bus_m.biu_ready = 1'b0;
      end else if (biu_stuck) begin
         bus_m.biu_ready = 1'b1;
      end else if (biu_busy) begin
         biu_cnt++;
         if (biu_cnt == BIU_LAT) begin
            bus_m.biu_ready = 1'b1;
            biu_busy        = 1'b0;
         end
      end else if (bus_m.biu_cs) begin
         bus_m.biu_ready = 1'b0;
         biu_busy        = 1'b1;
         biu_cnt         = 0;
      end else begin
         bus_m.biu_ready = 1'b1;
      end
      // Zero-wait memory for the wrap instance.
      bus_w.mem_ready = bus_w.mem_rd;
      bus_w.mem_data  = (bus_w.mem_addr == 16'hFFFE) ? 16'hC000 :
                        (bus_w.mem_addr == 16'hFFFF) ? 16'h1234 : 16'h0000;
      if (bus_w.mem_rd) begin
         check("w_fetch_q_nonempty", 32'(addr_w_q.size() != 0), 32'd1);
         if (addr_w_q.size() != 0) check("w_fetch_addr", 32'(bus_w.mem_addr), 32'(addr_w_q.pop_front()));
      end
   endtask

   task automatic wait_for(input int which, input string tag);
      int n;
      bit hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < WAIT_BUDGET) begin
         tick();
         n++;
         case (which)
            W_CS:    hit = bus_m.biu_cs;
            W_HALT:  hit = halted;
            W_ERR:   hit = err;
            default: hit = 1'b1;
         endcase
      end
      check({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pc"},       32'(pc),             32'h0000);
      check({tag, "_ir"},       bus_m.ir,            32'h0);
      check({tag, "_biu_sel"},  32'(bus_m.biu_sel),  32'd0);
      check({tag, "_biu_cs"},   32'(bus_m.biu_cs),   32'd0);
      check({tag, "_mem_rd"},   32'(bus_m.mem_rd),   32'd0);
      check({tag, "_mem_addr"}, 32'(bus_m.mem_addr), 32'd0);
      check({tag, "_halted"},   32'(halted),         32'd0);
      check({tag, "_err"},      32'(err),            32'd0);
   endtask

   task automatic push_program();
      for (int a = 0; a < 6; a++) addr_q.push_back(16'(a));
      sel_q.push_back(2'b00);
      sel_q.push_back(2'b01);
   endtask

   initial begin
      int rd0;
      rst = 1'b1; run = 1'b0; rst_w = 1'b1; run_w = 1'b0;
      bus_m.mem_ready = 1'b0; bus_m.mem_data = '0; bus_m.biu_ready = 1'b1;
      bus_w.mem_ready = 1'b0; bus_w.mem_data = '0; bus_w.biu_ready = 1'b1;
      mem_wait = 0; mem_cnt = 0; mem_pending = 1'b0; held_addr = '0;
      biu_force_low = 1'b0; biu_stuck = 1'b0; biu_busy = 1'b0; biu_cnt = 0;
      cs_prev = 1'b0; cs_pulses = 0; cs_high = 0; rd_cnt = 0;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      mem[0] = 16'h0008; mem[1] = 16'h2000;
      mem[2] = 16'h4000; mem[3] = 16'h0001;
      mem[4] = 16'hC000; mem[5] = 16'h0000;

      repeat (3) tick();
      check_reset_outputs("reset");
      check("w_reset_pc", 32'(pc_w), 32'h0000FFFE);

      // Fetch, dispatch, wait states and HALT from RESET_PC=0.
      push_program();
      addr_w_q.push_back(16'hFFFE);
      addr_w_q.push_back(16'hFFFF);
      rst = 1'b0; run = 1'b1; rst_w = 1'b0; run_w = 1'b1;
      wait_for(W_CS, "cs1");
      check("cs1_ir",  bus_m.ir,                32'h00082000);
      check("cs1_sel", 32'(bus_m.biu_sel),      32'd0);
      check("cs1_pc",  32'(pc),                 32'd2);
      mem_wait = 3;
      wait_for(W_CS, "cs2");
      check("cs2_ir",  bus_m.ir,                32'h40000001);
      check("cs2_sel", 32'(bus_m.biu_sel),      32'd1);
      check("cs2_pc",  32'(pc),                 32'd4);
      wait_for(W_HALT, "halt");
      check("halt_pc",        32'(pc),          32'd6);
      check("halt_ir",        bus_m.ir,         32'hC0000000);
      check("halt_cs_pulses", 32'(cs_pulses),   32'd2);
      rd0 = rd_cnt;
      repeat (8) tick();
      check("halt_pc_frozen", 32'(pc),          32'd6);
      check("halt_sticky",    32'(halted),      32'd1);
      check("halt_no_rd",     32'(rd_cnt - rd0), 32'd0);
      check("halt_no_cs",     32'(cs_pulses),   32'd2);

      // PC wrap instance ran alongside: FFFE, FFFF, then HALT with pc=0.
      check("w_halted", 32'(halted_w), 32'd1);
      check("w_pc",     32'(pc_w),     32'd0);
      check("w_ir",     bus_w.ir,      32'hC0001234);
      check("w_err",    32'(err_w),    32'd0);

      // A busy BIU in IDLE blocks the fetch; then a BIU that never accepts.
      rst = 1'b1; biu_force_low = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      rd0 = rd_cnt;
      repeat (6) tick();
      check("blocked_no_rd", 32'(rd_cnt - rd0), 32'd0);
      check("blocked_pc",    32'(pc),           32'd0);
      addr_q.push_back(16'h0000);
      addr_q.push_back(16'h0001);
      sel_q.push_back(2'b00);
      cs_high = 0;
      biu_stuck = 1'b1; biu_force_low = 1'b0;
      wait_for(W_ERR, "timeout");
      check("timeout_cs_cycles", 32'(cs_high),       32'(BIU_TO));
      check("timeout_cs_low",    32'(bus_m.biu_cs),  32'd0);
      check("timeout_halted",    32'(halted),        32'd0);
      rd0 = rd_cnt;
      repeat (5) tick();
      check("error_sticky", 32'(err),           32'd1);
      check("error_no_rd",  32'(rd_cnt - rd0),  32'd0);

      // Reset during WAIT_BIU, then a clean restart from RESET_PC.
      rst = 1'b1; biu_stuck = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      addr_q.push_back(16'h0000);
      addr_q.push_back(16'h0001);
      sel_q.push_back(2'b00);
      wait_for(W_CS, "pre_rst_cs");
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      push_program();
      wait_for(W_CS, "restart_cs1");
      check("restart_ir", bus_m.ir, 32'h00082000);
      check("restart_pc", 32'(pc),  32'd2);
      wait_for(W_CS, "restart_cs2");
      check("restart_pc2", 32'(pc), 32'd4);
      wait_for(W_HALT, "restart_halt");
      check("restart_halt_pc", 32'(pc), 32'd6);

      check("fetch_q_drained",   32'(addr_q.size()),   32'd0);
      check("sel_q_drained",     32'(sel_q.size()),    32'd0);
      check("w_fetch_q_drained", 32'(addr_w_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
